dmem_stream_loader: RTL and testbench

- Host-side writer that fills DataMemory over a valid/ready word stream before SMCore runs, then releases the core from reset.
- Write-direction counterpart of the end-of-run memory dump: data goes into DMem at addresses 0..DEPTH-1, then the program executes.
- Sits between an external host/stream source and the DMem write port inside System. It owns SMCore's reset until loading completes.

---
 rtl/dmem_stream_loader.sv | 155 +++++++++++++++
 tb/tb_dmem_stream_loader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_stream_loader.sv
// Host-side DMem loader: accepts a valid/ready word stream into DMem addresses 0..DEPTH-1,
// then releases SMCore from reset. Optional zero-fill of unloaded addresses: LOADER_ZERO_FILL_EN.
module dmem_stream_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int RESET_HOLD = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  core_reset,
    output logic                  load_done,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  overflow
);

    localparam int                     DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [7:0]             HOLD_END  = 8'(RESET_HOLD - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FILL,
        RELEASE,
        RUN
    } state_t;

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   ptr, ptr_n;
    logic [7:0]              hold, hold_n;
    logic                    s_ready_n;
    logic                    mem_we_n;
    logic [ADDR_WIDTH-1:0]   mem_addr_n;
    logic [DATA_WIDTH-1:0]   mem_wdata_n;
    logic                    core_reset_n;
    logic                    load_done_n;
    logic [ADDR_WIDTH:0]     word_count_n;
    logic                    overflow_n;
    logic                    hs;

    assign hs = s_valid && s_ready;

    always_comb begin
        state_n      = state;
        ptr_n        = ptr;
        hold_n       = hold;
        s_ready_n    = s_ready;
        mem_we_n     = 1'b0;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        core_reset_n = core_reset;
        load_done_n  = load_done;
        word_count_n = word_count;
        overflow_n   = overflow;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n   = LOAD;
                    s_ready_n = 1'b1;
                    ptr_n     = '0;
                end
            end
            LOAD: begin
                if (hs) begin
                    mem_we_n     = 1'b1;
                    mem_addr_n   = ptr;
                    mem_wdata_n  = s_data;
                    word_count_n = word_count + 1'b1;
                    if (s_last || ptr == LAST_ADDR) begin
                        // Drop ready on the accepting edge so no extra word slips in.
                        s_ready_n = 1'b0;
                        if (ptr == LAST_ADDR && !s_last)
                            overflow_n = 1'b1;
`ifdef LOADER_ZERO_FILL_EN
                        if (ptr != LAST_ADDR) begin
                            state_n = FILL;
                            ptr_n   = ptr + 1'b1;
                        end else begin
                            state_n = RELEASE;
                        end
`else
                        state_n = RELEASE;
`endif
                    end else begin
                        ptr_n = ptr + 1'b1;
                    end
                end
            end
`ifdef LOADER_ZERO_FILL_EN
            FILL: begin
                mem_we_n    = 1'b1;
                mem_addr_n  = ptr;
                mem_wdata_n = '0;
                if (ptr == LAST_ADDR)
                    state_n = RELEASE;
                else
                    ptr_n = ptr + 1'b1;
            end
`endif
            RELEASE: begin
                if (hold == HOLD_END) begin
                    core_reset_n = 1'b0;
                    load_done_n  = 1'b1;
                    state_n      = RUN;
                end else begin
                    hold_n = hold + 8'd1;
                end
            end
            RUN: begin
                state_n = RUN;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= '0;
            hold       <= '0;
            s_ready    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            word_count <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            hold       <= hold_n;
            s_ready    <= s_ready_n;
            mem_we     <= mem_we_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            core_reset <= core_reset_n;
            load_done  <= load_done_n;
            word_count <= word_count_n;
            overflow   <= overflow_n;
        end
    end

endmodule

// File: tb/tb_dmem_stream_loader.sv
// Scoreboard bench for dmem_stream_loader: expected DMem writes are queued at each handshake
// and checked by a write monitor; scenario tasks check control outputs inline.
module tb_dmem_stream_loader;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int HOLD  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          core_reset;
    logic          load_done;
    logic [AW:0]   word_count;
    logic          overflow;

    int n_cmp = 0;
    int n_err = 0;
    int exp_addr = 0;
    logic [AW+DW-1:0] exp_q[$];

    dmem_stream_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_HOLD(HOLD)) dut (
        .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .core_reset(core_reset), .load_done(load_done),
        .word_count(word_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Every DMem write must match the head of the expected-write queue.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", mem_addr, mem_wdata);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    n_err++;
                    $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                             mem_addr, mem_wdata, e[AW+DW-1:DW], e[DW-1:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b0;
        repeat (cycles) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_addr = 0;
    endtask

    // Offers words base+0.. with s_valid held high; s_last on word n-1 when use_last.
    // Returns on the cycle after the final accepted word or when the cycle budget runs out.
    task automatic send_words(input int n, input bit use_last, input int base, input int max_cyc,
                              output int accepted);
        accepted = 0;
        for (int c = 0; c < max_cyc && accepted < n; c++) begin
            s_valid = 1'b1;
            s_data  = DW'(base + accepted);
            s_last  = use_last && (accepted == n - 1);
            if (s_ready === 1'b1) begin
                exp_q.push_back({AW'(exp_addr), s_data});
                exp_addr++;
                accepted++;
            end
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
`ifdef LOADER_ZERO_FILL_EN
        if (use_last && accepted == n)
            for (int a = exp_addr; a < DEPTH; a++)
                exp_q.push_back({AW'(a), DW'(0)});
`endif
    endtask

    function automatic int fill_cycles(input int next_addr);
`ifdef LOADER_ZERO_FILL_EN
        return DEPTH - next_addr;
`else
        return 0 * next_addr;
`endif
    endfunction

    // Called one cycle after the last stream write edge; n cycles until release.
    task automatic check_release(input int n, input string tag);
        for (int i = 0; i < n - 1; i++) tick();
        n_cmp++;
        if (core_reset !== 1'b1) begin
            n_err++;
            $display("FAIL %s_hold: core_reset=%b, required 1", tag, core_reset);
        end
        tick();
        n_cmp++;
        if (core_reset !== 1'b0 || load_done !== 1'b1) begin
            n_err++;
            $display("FAIL %s_release: core_reset=%b load_done=%b, required 0 1", tag, core_reset, load_done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({s_ready, mem_we, mem_addr, mem_wdata, core_reset, load_done, word_count, overflow}
            !== {1'b0, 1'b0, AW'(0), DW'(0), 1'b1, 1'b0, (AW+1)'(0), 1'b0}) begin
            n_err++;
            $display("FAIL reset_values: rdy=%b we=%b addr=%0d wd=%h crst=%b done=%b cnt=%0d ovf=%b, required 0 0 0 0 1 0 0 0",
                     s_ready, mem_we, mem_addr, mem_wdata, core_reset, load_done, word_count, overflow);
        end
        reset = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (s_ready !== 1'b0 || core_reset !== 1'b1) begin
            n_err++;
            $display("FAIL idle_after_reset: s_ready=%b core_reset=%b, required 0 1", s_ready, core_reset);
        end
    endtask

    task automatic test_basic();
        int acc;
        apply_reset(1);
        pulse_start();
        n_cmp++;
        if (s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL basic_ready: s_ready=%b, required 1", s_ready);
        end
        send_words(4, 1'b1, 1, 10, acc);
        n_cmp++;
        if (acc !== 4 || word_count !== (AW+1)'(4) || overflow !== 1'b0 || s_ready !== 1'b0) begin
            n_err++;
            $display("FAIL basic_count: acc=%0d word_count=%0d overflow=%b s_ready=%b, required 4 4 0 0",
                     acc, word_count, overflow, s_ready);
        end
        check_release(fill_cycles(4) + HOLD, "basic");
    endtask

    task automatic test_gap();
        apply_reset(1);
        pulse_start();
        for (int c = 0; c < 8; c++) begin
            s_valid = (c % 2 == 0);
            s_data  = DW'(16'h0A00 + c / 2);
            s_last  = (c == 6);
            if (s_valid && s_ready === 1'b1) begin
                exp_q.push_back({AW'(exp_addr), s_data});
                exp_addr++;
            end
            tick();
            if (c == 6) break;
            if (!s_valid) begin
                n_cmp++;
                if (mem_we !== 1'b0) begin
                    n_err++;
                    $display("FAIL gap_we: cycle %0d mem_we=%b, required 0", c, mem_we);
                end
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
`ifdef LOADER_ZERO_FILL_EN
        for (int a = exp_addr; a < DEPTH; a++) exp_q.push_back({AW'(a), DW'(0)});
`endif
        n_cmp++;
        if (word_count !== (AW+1)'(4) || exp_addr != 4) begin
            n_err++;
            $display("FAIL gap_count: word_count=%0d accepted=%0d, required 4 4", word_count, exp_addr);
        end
        check_release(fill_cycles(4) + HOLD, "gap");
    endtask

    task automatic test_overflow();
        int acc;
        apply_reset(1);
        pulse_start();
        send_words(33, 1'b0, 16'h0100, 40, acc);
        n_cmp++;
        if (acc !== 32 || s_ready !== 1'b0 || overflow !== 1'b1 || word_count !== (AW+1)'(32)) begin
            n_err++;
            $display("FAIL overflow: acc=%0d s_ready=%b overflow=%b word_count=%0d, required 32 0 1 32",
                     acc, s_ready, overflow, word_count);
        end
        n_cmp++;
        if (core_reset !== 1'b0 || load_done !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_release: core_reset=%b load_done=%b, required 0 1", core_reset, load_done);
        end
    endtask

    task automatic test_midreset();
        int acc;
        apply_reset(1);
        pulse_start();
        send_words(3, 1'b0, 16'h0300, 5, acc);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        n_cmp++;
        if (word_count !== '0 || mem_we !== 1'b0 || core_reset !== 1'b1 || s_ready !== 1'b0) begin
            n_err++;
            $display("FAIL midreset: word_count=%0d mem_we=%b core_reset=%b s_ready=%b, required 0 0 1 0",
                     word_count, mem_we, core_reset, s_ready);
        end
        reset = 1'b1;
        tick();
        pulse_start();
        send_words(2, 1'b1, 16'h0400, 5, acc);
        n_cmp++;
        if (word_count !== (AW+1)'(2) || core_reset !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_restart: word_count=%0d core_reset=%b, required 2 1", word_count, core_reset);
        end
        check_release(fill_cycles(2) + HOLD, "midreset");
    endtask

    task automatic test_ignore();
        int acc;
        apply_reset(1);
        s_valid = 1'b1;
        s_data  = 16'hDEAD;
        repeat (3) tick();
        s_valid = 1'b0;
        n_cmp++;
        if (s_ready !== 1'b0 || word_count !== '0) begin
            n_err++;
            $display("FAIL idle_valid: s_ready=%b word_count=%0d, required 0 0", s_ready, word_count);
        end
        pulse_start();
        send_words(1, 1'b0, 16'h0500, 3, acc);
        start = 1'b1;
        send_words(1, 1'b0, 16'h0501, 3, acc);
        start = 1'b0;
        send_words(1, 1'b1, 16'h0502, 3, acc);
        n_cmp++;
        if (word_count !== (AW+1)'(3)) begin
            n_err++;
            $display("FAIL load_start_ignored: word_count=%0d, required 3", word_count);
        end
        check_release(fill_cycles(3) + HOLD, "ignore");
        start   = 1'b1;
        s_valid = 1'b1;
        s_last  = 1'b1;
        repeat (3) tick();
        start   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        tick();
        n_cmp++;
        if (core_reset !== 1'b0 || load_done !== 1'b1 || s_ready !== 1'b0 || word_count !== (AW+1)'(3)) begin
            n_err++;
            $display("FAIL run_ignore: core_reset=%b load_done=%b s_ready=%b word_count=%0d, required 0 1 0 3",
                     core_reset, load_done, s_ready, word_count);
        end
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_gap();
        test_overflow();
        test_midreset();
        test_ignore();
        repeat (2) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_writes: %0d expected writes never appeared, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
